// File: rtl/pixel_stream_packer.sv
// Packs a stream of 24-bit pixels into 32-bit words (4 pixels -> 3 words).
// The words go into a small output FIFO that carries start-of-frame (tuser)
// and end-of-line (tlast) flags. Misaligned line starts and ends set a sticky
// error flag and resynchronise the packing phase.
module pixel_stream_packer #(
  parameter int DATA_WIDTH    = 32,
  parameter int RBG_SIZE      = 24,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RBG_SIZE-1:0]   in_colour,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_y,
  output logic [31:0]           m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tuser,
  output logic                  m_tlast,
  output logic [15:0]           frame_count,
  output logic                  err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] X_LAST   = DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST   = DATA_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [CW-1:0]         DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0]         PTR_LAST = AW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

  phase_t        phase_q, phase_d, eff_phase;
  logic [23:0]   hold_q, hold_d;
  logic          sof_q, sof_d;
  logic          in_ready_q;
  logic          err_q, err_set;
  logic [15:0]   frame_count_q;

  logic          accept, first_px, last_px, sof_px, bottom_px;
  logic          push, pop, push_user, push_last;
  logic [31:0]   push_data;

  logic [33:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [33:0]   head;

  assign accept    = in_valid && in_ready_q;
  assign first_px  = (in_x == '0);
  assign last_px   = (in_x == X_LAST);
  assign sof_px    = first_px && (in_y == '0);
  assign bottom_px = (in_y == Y_LAST);

  // Packing phase machine: decides what to hold and which word to push.
  // A line end at any phase other than P3 pushes the bytes of the word being
  // built (zero-padded when only one pixel is held) and drops any remainder.
  always_comb begin
    phase_d   = phase_q;
    hold_d    = hold_q;
    sof_d     = sof_q;
    push      = 1'b0;
    push_data = '0;
    push_user = 1'b0;
    push_last = 1'b0;
    err_set   = 1'b0;
    eff_phase = first_px ? P0 : phase_q;
    if (accept) begin
      if (first_px && (phase_q != P0)) err_set = 1'b1;
      unique case (eff_phase)
        P0: begin
          if (last_px) begin
            push      = 1'b1;
            push_data = {8'h00, in_colour[23:0]};
            push_last = 1'b1;
            err_set   = 1'b1;
            hold_d    = '0;
            sof_d     = 1'b0;
            phase_d   = P0;
          end else begin
            hold_d  = in_colour[23:0];
            sof_d   = sof_px;
            phase_d = P1;
          end
        end
        P1: begin
          push      = 1'b1;
          push_data = {in_colour[7:0], hold_q};
          push_user = sof_q;
          sof_d     = 1'b0;
          if (last_px) begin
            push_last = 1'b1;
            err_set   = 1'b1;
            hold_d    = '0;
            phase_d   = P0;
          end else begin
            hold_d  = {8'h00, in_colour[23:8]};
            phase_d = P2;
          end
        end
        P2: begin
          push      = 1'b1;
          push_data = {in_colour[15:0], hold_q[15:0]};
          if (last_px) begin
            push_last = 1'b1;
            err_set   = 1'b1;
            hold_d    = '0;
            phase_d   = P0;
          end else begin
            hold_d  = {16'h0000, in_colour[23:16]};
            phase_d = P3;
          end
        end
        default: begin
          push      = 1'b1;
          push_data = {in_colour[23:0], hold_q[7:0]};
          push_last = last_px;
          hold_d    = '0;
          phase_d   = P0;
        end
      endcase
    end
  end

  // FIFO occupancy bookkeeping; push and pop in one cycle cancel out.
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // FIFO storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, push_user, push_data};
  end

  // Control state: phase, held bytes, FIFO pointers, ready, flags, counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= P0;
      hold_q        <= '0;
      sof_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b1;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      sof_q      <= sof_d;
      count_q    <= count_d;
      in_ready_q <= (count_d < DEPTH_C);
      err_q      <= err_q | err_set;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
      if (push && push_last && bottom_px) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign m_tvalid    = (count_q != '0);
  assign pop         = m_tvalid && m_tready;
  assign head        = m_tvalid ? mem_q[rd_ptr_q] : '0;
  assign m_tdata     = head[31:0];
  assign m_tuser     = head[32];
  assign m_tlast     = head[33];
  assign in_ready    = in_ready_q;
  assign err         = err_q;
  assign frame_count = frame_count_q;

endmodule
